alu_writeback: RTL and testbench

Commit stage directly downstream of the combinational ALU. On each execute strobe it captures the ALU's results and flags, and drives the register-file write port. It owns the 8-bit status register that feeds the ALU's status input, and sequences the two-word MUL writeback, holding busy to stall the sequencer.

---
 rtl/alu_writeback.sv | 88 ++++++++
 tb/tb_alu_writeback.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: ALU commit stage that owns the status register and sequences the two-word MUL writeback
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter logic [7:0] STATUS_RST = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exec2,
  input  logic [5:0]        encoded_opcode,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] aluout1,
  input  logic [DATA_W-1:0] aluout2,
  input  logic [7:0]        alu_flags,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [7:0]        statusreg,
  output logic              busy,
  output logic              overrun
);
  typedef enum logic [0:0] {IDLE, MUL_LO} state_e;
  state_e state_q;
  logic              we_q, busy_q, overrun_q;
  logic [ADDR_W-1:0] waddr_q, lo_addr_q;
  logic [DATA_W-1:0] wdata_q, lo_data_q;
  logic [7:0]        status_q, status_d, mask;
  logic [5:0]        op, fop;
  logic              wr_cls, znc, zn, fl_op, is_mul, unused_bits;
  assign op = encoded_opcode;
  assign unused_bits = ^{alu_flags[7:3], fop[5:4]};
  always_comb begin
    wr_cls = (op >= 6'h03 && op <= 6'h09) || (op >= 6'h11 && op <= 6'h14) ||
             op == 6'h17 || op == 6'h18 || (op >= 6'h1D && op <= 6'h1F);
    znc    = (op >= 6'h07 && op <= 6'h09) || (op >= 6'h11 && op <= 6'h16);
    zn     = op == 6'h06 || (op >= 6'h1D && op <= 6'h1F);
    fl_op  = op >= 6'h29 && op <= 6'h36;
    is_mul = op == 6'h21;
    // flag ops come in set/clear pairs starting at 0x29: bit index is offset/2, odd offset clears
    fop    = op - 6'h29;
    mask   = 8'd1 << fop[3:1];
    status_d = 8'h7F & (fl_op ? (fop[0] ? status_q & ~mask : status_q | mask) :
                        znc   ? {status_q[7:3], alu_flags[2:0]} :
                        zn    ? {status_q[7:2], alu_flags[1:0]} : status_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      lo_addr_q <= '0;
      lo_data_q <= '0;
      status_q  <= STATUS_RST & 8'h7F;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (state_q == MUL_LO) begin
        we_q      <= 1'b1;
        waddr_q   <= lo_addr_q;
        wdata_q   <= lo_data_q;
        busy_q    <= 1'b0;
        state_q   <= IDLE;
        overrun_q <= overrun_q | exec2;
      end else if (exec2) begin
        status_q <= status_d;
        if (wr_cls || is_mul) begin
          we_q    <= 1'b1;
          waddr_q <= rd_addr;
          wdata_q <= aluout1;
        end
        if (is_mul) begin
          lo_addr_q <= rd_addr + 1'b1;
          lo_data_q <= aluout2;
          busy_q    <= 1'b1;
          state_q   <= MUL_LO;
        end
      end
    end
  end
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign statusreg = status_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed per-feature tests of the ALU writeback stage
module tb_alu_writeback;
  logic        clk = 0, reset = 0, exec2 = 0;
  logic [5:0]  encoded_opcode = 0;
  logic [2:0]  rd_addr = 0;
  logic [15:0] aluout1 = 0, aluout2 = 0;
  logic [7:0]  alu_flags = 0;
  logic        rf_we, busy, overrun;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  statusreg;
  int total = 0, bad = 0;

  alu_writeback #(.DATA_W(16), .ADDR_W(3), .STATUS_RST(8'hFF)) dut (
    .clk(clk), .reset(reset), .exec2(exec2), .encoded_opcode(encoded_opcode),
    .rd_addr(rd_addr), .aluout1(aluout1), .aluout2(aluout2), .alu_flags(alu_flags),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .statusreg(statusreg),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [7:0] fl);
    exec2 = 1; encoded_opcode = op; rd_addr = rd; aluout1 = a1; aluout2 = a2; alu_flags = fl;
    step();
    exec2 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    #3;
    total++; if (statusreg !== 8'h7F) begin bad++; $display("FAIL rst_status got=%0h exp=7f", statusreg); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", rf_we); end
    total++; if (busy !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rst_busy_ovr got=%0b%0b exp=00", busy, overrun); end
    total++; if (rf_waddr !== 3'd0 || rf_wdata !== 16'h0) begin bad++; $display("FAIL rst_wport got=%0h/%0h exp=0/0", rf_waddr, rf_wdata); end
    step();
    reset = 0;
    step();
    issue(6'h2A, 3'd0, 16'h0, 16'h0, 8'h00);
    total++; if (statusreg !== 8'h7E) begin bad++; $display("FAIL clz_status got=%0h exp=7e", statusreg); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL clz_we got=%0b exp=0", rf_we); end
  endtask

  task automatic test_write();
    issue(6'h11, 3'd3, 16'h0000, 16'h0, 8'h05);
    total++; if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h0000) begin bad++; $display("FAIL add_write got=%0b/%0h/%0h exp=1/3/0", rf_we, rf_waddr, rf_wdata); end
    total++; if (statusreg !== 8'h7D) begin bad++; $display("FAIL add_status got=%0h exp=7d", statusreg); end
    step();
    total++; if (rf_we !== 1'b0 || rf_waddr !== 3'd3) begin bad++; $display("FAIL add_idle got=%0b/%0h exp=0/3", rf_we, rf_waddr); end
    issue(6'h17, 3'd5, 16'hBEEF, 16'h0, 8'h07);
    total++; if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 16'hBEEF) begin bad++; $display("FAIL mov_write got=%0b/%0h/%0h exp=1/5/beef", rf_we, rf_waddr, rf_wdata); end
    total++; if (statusreg !== 8'h7D) begin bad++; $display("FAIL mov_status got=%0h exp=7d", statusreg); end
    issue(6'h06, 3'd1, 16'h8001, 16'h0, 8'h06);
    total++; if (rf_we !== 1'b1 || rf_wdata !== 16'h8001) begin bad++; $display("FAIL inv_write got=%0b/%0h exp=1/8001", rf_we, rf_wdata); end
    total++; if (statusreg !== 8'h7E) begin bad++; $display("FAIL inv_status got=%0h exp=7e", statusreg); end
    issue(6'h00, 3'd2, 16'h1111, 16'h0, 8'h07);
    total++; if (rf_we !== 1'b0 || statusreg !== 8'h7E || rf_wdata !== 16'h8001) begin bad++; $display("FAIL nop got=%0b/%0h/%0h exp=0/7e/8001", rf_we, statusreg, rf_wdata); end
  endtask

  task automatic test_mul();
    issue(6'h21, 3'd7, 16'h1234, 16'hABCD, 8'hFF);
    total++; if (rf_we !== 1'b1 || rf_waddr !== 3'd7 || rf_wdata !== 16'h1234 || busy !== 1'b1) begin bad++; $display("FAIL mul_hi got=%0b/%0h/%0h/%0b exp=1/7/1234/1", rf_we, rf_waddr, rf_wdata, busy); end
    step();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 3'd0 || rf_wdata !== 16'hABCD || busy !== 1'b0) begin bad++; $display("FAIL mul_lo got=%0b/%0h/%0h/%0b exp=1/0/abcd/0", rf_we, rf_waddr, rf_wdata, busy); end
    total++; if (statusreg !== 8'h7E) begin bad++; $display("FAIL mul_status got=%0h exp=7e", statusreg); end
    step();
    total++; if (rf_we !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL mul_done got=%0b/%0b exp=0/0", rf_we, overrun); end
  endtask

  task automatic test_back_to_back();
    issue(6'h21, 3'd2, 16'h0F0F, 16'h5A5A, 8'h00);
    issue(6'h11, 3'd5, 16'h5555, 16'h0, 8'h00);
    total++; if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h5A5A) begin bad++; $display("FAIL b2b_lo got=%0b/%0h/%0h exp=1/3/5a5a", rf_we, rf_waddr, rf_wdata); end
    total++; if (overrun !== 1'b1 || statusreg !== 8'h7E) begin bad++; $display("FAIL b2b_ovr got=%0b/%0h exp=1/7e", overrun, statusreg); end
    step();
    total++; if (rf_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%0b/%0b exp=0/0", rf_we, busy); end
    step(); step();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_sticky got=%0b exp=1", overrun); end
  endtask

  task automatic test_flags();
    issue(6'h16, 3'd4, 16'hFFFF, 16'h0, 8'h03);
    total++; if (rf_we !== 1'b0 || statusreg !== 8'h7B) begin bad++; $display("FAIL ghs got=%0b/%0h exp=0/7b", rf_we, statusreg); end
    issue(6'h2D, 3'd0, 16'h0, 16'h0, 8'h00);
    total++; if (statusreg !== 8'h7F) begin bad++; $display("FAIL sec got=%0h exp=7f", statusreg); end
    issue(6'h36, 3'd0, 16'h0, 16'h0, 8'h00);
    total++; if (statusreg !== 8'h3F) begin bad++; $display("FAIL cli got=%0h exp=3f", statusreg); end
  endtask

  task automatic test_reset_mid_mul();
    issue(6'h21, 3'd4, 16'hCAFE, 16'hF00D, 8'h00);
    total++; if (busy !== 1'b1 || rf_we !== 1'b1) begin bad++; $display("FAIL rmul_pre got=%0b/%0b exp=1/1", busy, rf_we); end
    reset = 1;
    #1;
    total++; if (rf_we !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || statusreg !== 8'h7F) begin bad++; $display("FAIL rmul_async got=%0b/%0b/%0b/%0h exp=0/0/0/7f", rf_we, busy, overrun, statusreg); end
    #1;
    reset = 0;
    step();
    total++; if (rf_we !== 1'b0 || rf_wdata !== 16'h0) begin bad++; $display("FAIL rmul_nowr got=%0b/%0h exp=0/0", rf_we, rf_wdata); end
    step();
    total++; if (rf_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmul_idle got=%0b/%0b exp=0/0", rf_we, busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mul();
    test_back_to_back();
    test_flags();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
